regfile_wb_queue: RTL and testbench

Write-back queue sitting in front of the 32x32 register file's single write port. Accepts completed results (destination index plus data) from the execute/load side through a valid/ready handshake, buffers them in order, and drains at most one per cycle onto the register file's `reg_write`/`rd`/`rd_data` inputs. Provides two combinational bypass lookups so decode reads see results that are still queued and not yet written.

---
 rtl/regfile_wb_queue_pkg.sv | 14 +
 rtl/wb_bypass_lookup.sv | 34 +++
 rtl/regfile_wb_queue.sv | 115 +++++++++++
 tb/tb_regfile_wb_queue.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_queue_pkg.sv
// Shared types for the register-file write-back path.
package regfile_wb_queue_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t         rd;
    logic [XLEN-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/wb_bypass_lookup.sv
// Youngest-match search over the write-back queue for one decode read port.
module wb_bypass_lookup
  import regfile_wb_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = regfile_wb_queue_pkg::XLEN,
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][REG_IDX_W-1:0] ent_rd,
  input  logic [DEPTH-1:0][XLEN-1:0]      ent_data,
  input  logic [DEPTH-1:0]                ent_valid,
  input  logic [PtrW-1:0]                 head,
  input  logic [REG_IDX_W-1:0]            rs,
  output logic                            hit,
  output logic [XLEN-1:0]                 data
);

  logic [PtrW-1:0] idx;

  // Walk oldest to youngest from the head so the last match wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PtrW'(i);
      if (ent_valid[idx] && (ent_rd[idx] == rs) && (rs != '0)) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// In-order write-back queue in front of the register file write port, with
// two combinational bypass lookups over the queued results.
module regfile_wb_queue
  import regfile_wb_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = regfile_wb_queue_pkg::XLEN,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_IDX_W-1:0] in_rd,
  input  logic [XLEN-1:0]      in_data,
  input  logic                 wb_hold,
  output logic                 reg_write,
  output logic [REG_IDX_W-1:0] rd,
  output logic [XLEN-1:0]      rd_data,
  input  logic [REG_IDX_W-1:0] byp_rs1,
  input  logic [REG_IDX_W-1:0] byp_rs2,
  output logic                 byp_hit1,
  output logic                 byp_hit2,
  output logic [XLEN-1:0]      byp_data1,
  output logic [XLEN-1:0]      byp_data2,
  output logic [CntW-1:0]      count,
  output logic                 empty,
  output logic                 full
);

  logic [DEPTH-1:0][REG_IDX_W-1:0] ent_rd_q;
  logic [DEPTH-1:0][XLEN-1:0]      ent_data_q;
  logic [DEPTH-1:0]                ent_valid;
  logic [PtrW-1:0]                 wptr_q, rptr_q;
  logic [CntW-1:0]                 count_q, count_d;
  logic                            push, pop;
  logic [PtrW-1:0]                 age;

  // Status and drain outputs come from registered state only.
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CntW'(DEPTH));
    in_ready  = !full;
    reg_write = !empty && !wb_hold;
    rd        = empty ? '0 : ent_rd_q[rptr_q];
    rd_data   = empty ? '0 : ent_data_q[rptr_q];
    count     = count_q;
  end

  // x0 writes complete the handshake but are dropped rather than queued.
  always_comb begin
    push    = in_valid && in_ready && (in_rd != '0);
    pop     = reg_write;
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  // Slot i is occupied when its distance from the head is below the count.
  always_comb begin
    ent_valid = '0;
    age       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      age          = PtrW'(i) - rptr_q;
      ent_valid[i] = ({1'b0, age} < count_q);
    end
  end

  // Pointers, occupancy and entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      ent_rd_q   <= '0;
      ent_data_q <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        ent_rd_q[wptr_q]   <= in_rd;
        ent_data_q[wptr_q] <= in_data;
        wptr_q             <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

  wb_bypass_lookup #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_byp1 (
    .ent_rd    (ent_rd_q),
    .ent_data  (ent_data_q),
    .ent_valid (ent_valid),
    .head      (rptr_q),
    .rs        (byp_rs1),
    .hit       (byp_hit1),
    .data      (byp_data1)
  );

  wb_bypass_lookup #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_byp2 (
    .ent_rd    (ent_rd_q),
    .ent_data  (ent_data_q),
    .ent_valid (ent_valid),
    .head      (rptr_q),
    .rs        (byp_rs2),
    .hit       (byp_hit2),
    .data      (byp_data2)
  );

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue: vector table plus multi-cycle sequences.
module tb_regfile_wb_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        wb_hold;
  logic        reg_write;
  logic [4:0]  rd;
  logic [31:0] rd_data;
  logic [4:0]  byp_rs1, byp_rs2;
  logic        byp_hit1, byp_hit2;
  logic [31:0] byp_data1, byp_data2;
  logic [2:0]  count;
  logic        empty, full;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_wb_queue #(
    .DEPTH (4),
    .XLEN  (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rd     (in_rd),
    .in_data   (in_data),
    .wb_hold   (wb_hold),
    .reg_write (reg_write),
    .rd        (rd),
    .rd_data   (rd_data),
    .byp_rs1   (byp_rs1),
    .byp_rs2   (byp_rs2),
    .byp_hit1  (byp_hit1),
    .byp_hit2  (byp_hit2),
    .byp_data1 (byp_data1),
    .byp_data2 (byp_data2),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  typedef struct {
    logic        v;
    logic [4:0]  ird;
    logic [31:0] idata;
    logic        hold;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        ew;
    logic [4:0]  erd;
    logic [31:0] edata;
    logic [2:0]  ecnt;
    logic        erdy;
    logic        eh1;
    logic [31:0] ed1;
    logic        eh2;
    logic [31:0] ed2;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } wr_t;

  vec_t vecs[$];
  wr_t  log_q[$];
  wr_t  exp_q[$];

  // Record every register-file write, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && reg_write) log_q.push_back('{rd: rd, d: rd_data});
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [4:0] ird, input logic [31:0] idata,
                              input logic hold, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic ew, input logic [4:0] erd, input logic [31:0] edata,
                              input logic [2:0] ecnt, input logic erdy,
                              input logic eh1, input logic [31:0] ed1,
                              input logic eh2, input logic [31:0] ed2);
    vec_t t;
    t.v = v; t.ird = ird; t.idata = idata; t.hold = hold; t.rs1 = rs1; t.rs2 = rs2;
    t.ew = ew; t.erd = erd; t.edata = edata; t.ecnt = ecnt; t.erdy = erdy;
    t.eh1 = eh1; t.ed1 = ed1; t.eh2 = eh2; t.ed2 = ed2;
    return t;
  endfunction

  task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d,
                       input logic h);
    in_valid = v;
    in_rd    = r;
    in_data  = d;
    wb_hold  = h;
  endtask

  task automatic check_log(input string nm);
    chk($sformatf("%s_len", nm), 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk($sformatf("%s_rd%0d", nm, i), 64'(log_q[i].rd), 64'(exp_q[i].rd));
      chk($sformatf("%s_data%0d", nm, i), 64'(log_q[i].d), 64'(exp_q[i].d));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    byp_rs1 = 5'd0;
    byp_rs2 = 5'd0;

    //            v  ird   idata          hold rs1 rs2  w  rd    data           c  rdy h1 d1 h2 d2
    vecs.push_back(mk(0, 5'd0, 32'h0,        0, 5'd0, 5'd0, 0, 5'd0, 32'h0,        3'd0, 1, 0, 32'h0, 0, 32'h0));
    vecs.push_back(mk(1, 5'd5, 32'hDEADBEEF, 0, 5'd5, 5'd0, 0, 5'd0, 32'h0,        3'd0, 1, 0, 32'h0, 0, 32'h0));
    vecs.push_back(mk(0, 5'd0, 32'h0,        0, 5'd5, 5'd5, 1, 5'd5, 32'hDEADBEEF, 3'd1, 1,
                      1, 32'hDEADBEEF, 1, 32'hDEADBEEF));
    vecs.push_back(mk(0, 5'd0, 32'h0,        1, 5'd5, 5'd0, 0, 5'd0, 32'h0,        3'd0, 1, 0, 32'h0, 0, 32'h0));
    vecs.push_back(mk(1, 5'd3, 32'h11,       1, 5'd0, 5'd0, 0, 5'd0, 32'h0,        3'd0, 1, 0, 32'h0, 0, 32'h0));
    vecs.push_back(mk(1, 5'd7, 32'h22,       1, 5'd3, 5'd7, 0, 5'd3, 32'h11,       3'd1, 1, 1, 32'h11, 0, 32'h0));
    vecs.push_back(mk(1, 5'd3, 32'h33,       1, 5'd3, 5'd7, 0, 5'd3, 32'h11,       3'd2, 1, 1, 32'h11, 1, 32'h22));
    vecs.push_back(mk(1, 5'd9, 32'h44,       1, 5'd3, 5'd9, 0, 5'd3, 32'h11,       3'd3, 1, 1, 32'h33, 0, 32'h0));
    vecs.push_back(mk(1, 5'd1, 32'h99,       1, 5'd3, 5'd8, 0, 5'd3, 32'h11,       3'd4, 0, 1, 32'h33, 0, 32'h0));
    vecs.push_back(mk(1, 5'd1, 32'h99,       0, 5'd7, 5'd9, 1, 5'd3, 32'h11,       3'd4, 0, 1, 32'h22, 1, 32'h44));
    vecs.push_back(mk(1, 5'd1, 32'h99,       1, 5'd3, 5'd1, 0, 5'd7, 32'h22,       3'd3, 1, 1, 32'h33, 0, 32'h0));
    vecs.push_back(mk(0, 5'd0, 32'h0,        1, 5'd1, 5'd3, 0, 5'd7, 32'h22,       3'd4, 0, 1, 32'h99, 1, 32'h33));
    vecs.push_back(mk(0, 5'd0, 32'h0,        0, 5'd3, 5'd7, 1, 5'd7, 32'h22,       3'd4, 0, 1, 32'h33, 1, 32'h22));
    vecs.push_back(mk(0, 5'd0, 32'h0,        0, 5'd3, 5'd7, 1, 5'd3, 32'h33,       3'd3, 1, 1, 32'h33, 0, 32'h0));
    vecs.push_back(mk(0, 5'd0, 32'h0,        0, 5'd9, 5'd3, 1, 5'd9, 32'h44,       3'd2, 1, 1, 32'h44, 0, 32'h0));
    vecs.push_back(mk(0, 5'd0, 32'h0,        0, 5'd1, 5'd9, 1, 5'd1, 32'h99,       3'd1, 1, 1, 32'h99, 0, 32'h0));
    vecs.push_back(mk(1, 5'd0, 32'h55,       0, 5'd0, 5'd1, 0, 5'd0, 32'h0,        3'd0, 1, 0, 32'h0, 0, 32'h0));
    vecs.push_back(mk(1, 5'd3, 32'h77,       1, 5'd0, 5'd0, 0, 5'd0, 32'h0,        3'd0, 1, 0, 32'h0, 0, 32'h0));
    vecs.push_back(mk(0, 5'd0, 32'h0,        1, 5'd3, 5'd0, 0, 5'd3, 32'h77,       3'd1, 1, 1, 32'h77, 0, 32'h0));
    vecs.push_back(mk(0, 5'd0, 32'h0,        0, 5'd0, 5'd3, 1, 5'd3, 32'h77,       3'd1, 1, 0, 32'h0, 1, 32'h77));
    vecs.push_back(mk(0, 5'd0, 32'h0,        0, 5'd0, 5'd0, 0, 5'd0, 32'h0,        3'd0, 1, 0, 32'h0, 0, 32'h0));

    #12 rst_n = 1'b1;

    // Table: inputs driven 1 ns after the edge, outputs checked 2 ns later.
    foreach (vecs[k]) begin
      @(posedge clk);
      #1;
      drive(vecs[k].v, vecs[k].ird, vecs[k].idata, vecs[k].hold);
      byp_rs1 = vecs[k].rs1;
      byp_rs2 = vecs[k].rs2;
      #2;
      chk($sformatf("v%0d_reg_write", k), 64'(reg_write), 64'(vecs[k].ew));
      chk($sformatf("v%0d_rd", k),        64'(rd),        64'(vecs[k].erd));
      chk($sformatf("v%0d_rd_data", k),   64'(rd_data),   64'(vecs[k].edata));
      chk($sformatf("v%0d_count", k),     64'(count),     64'(vecs[k].ecnt));
      chk($sformatf("v%0d_in_ready", k),  64'(in_ready),  64'(vecs[k].erdy));
      chk($sformatf("v%0d_empty", k),     64'(empty),     64'(vecs[k].ecnt == 3'd0));
      chk($sformatf("v%0d_full", k),      64'(full),      64'(vecs[k].ecnt == 3'd4));
      chk($sformatf("v%0d_hit1", k),      64'(byp_hit1),  64'(vecs[k].eh1));
      chk($sformatf("v%0d_data1", k),     64'(byp_data1), 64'(vecs[k].ed1));
      chk($sformatf("v%0d_hit2", k),      64'(byp_hit2),  64'(vecs[k].eh2));
      chk($sformatf("v%0d_data2", k),     64'(byp_data2), 64'(vecs[k].ed2));
    end

    exp_q = '{'{5'd5, 32'hDEADBEEF}, '{5'd3, 32'h11}, '{5'd7, 32'h22}, '{5'd3, 32'h33},
              '{5'd9, 32'h44}, '{5'd1, 32'h99}, '{5'd3, 32'h77}};
    check_log("table_order");

    // Streaming: one accept per cycle with no hold; pointers wrap several times.
    log_q.delete();
    exp_q.delete();
    byp_rs1 = 5'd0;
    byp_rs2 = 5'd0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      drive(1'b1, 5'((i % 31) + 1), 32'h1000 + 32'(i), 1'b0);
      exp_q.push_back('{rd: 5'((i % 31) + 1), d: 32'h1000 + 32'(i)});
      #2;
      chk($sformatf("stream%0d_count", i), 64'(count <= 3'd1), 64'd1);
    end
    @(posedge clk);
    #1;
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    chk("stream_empty", 64'(empty), 64'd1);
    check_log("stream");

    // Asynchronous reset with a full held queue: nothing may be written afterwards.
    log_q.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      drive(1'b1, 5'(10 + i), 32'hA0 + 32'(i), 1'b1);
    end
    @(posedge clk);
    #1;
    drive(1'b0, 5'd0, 32'd0, 1'b1);
    byp_rs1 = 5'd11;
    byp_rs2 = 5'd13;
    #2;
    chk("rst_pre_full", 64'(full), 64'd1);
    chk("rst_pre_hit1", 64'(byp_hit1), 64'd1);
    #1 rst_n = 1'b0;
    wb_hold = 1'b0;
    #1;
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_empty",     64'(empty),     64'd1);
    chk("rst_full",      64'(full),      64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_reg_write", 64'(reg_write), 64'd0);
    chk("rst_rd",        64'(rd),        64'd0);
    chk("rst_rd_data",   64'(rd_data),   64'd0);
    chk("rst_hit1",      64'(byp_hit1),  64'd0);
    chk("rst_hit2",      64'(byp_hit2),  64'd0);
    chk("rst_data1",     64'(byp_data1), 64'd0);
    chk("rst_data2",     64'(byp_data2), 64'd0);
    #13 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    chk("rst_post_count", 64'(count), 64'd0);
    check_log("rst_no_write");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
